// File: rtl/iotdf_pkg.sv
// Shared definitions for the IoT data-filter generator: mode encodings,
// FSM state type and the constants derived from word/beat geometry.
package iotdf_pkg;

  typedef enum logic [2:0] {
    FN_IDLE    = 3'd0,
    FN_MAX     = 3'd1,
    FN_MIN     = 3'd2,
    FN_AVG     = 3'd3,
    FN_EXTRACT = 3'd4,
    FN_EXCLUDE = 3'd5,
    FN_PEAKMAX = 3'd6,
    FN_PEAKMIN = 3'd7
  } fn_e;

  typedef enum logic {
    RUN = 1'b0,
    FIN = 1'b1
  } state_e;

  localparam int DEF_IN_W    = 8;
  localparam int DEF_WORD_W  = 128;
  localparam int DEF_N_WORDS = 8;
  localparam int BEATS       = DEF_WORD_W / DEF_IN_W;
  localparam int RND_W       = $clog2(DEF_N_WORDS);

  // Parameterised forms of BEATS / RND_W for non-default instances.
  function automatic int beats_of(input int word_w, input int in_w);
    return word_w / in_w;
  endfunction

  function automatic int rnd_w_of(input int n_words);
    return $clog2(n_words);
  endfunction

endpackage

// File: rtl/iotdf_word_asm.sv
// Beat-to-word assembler: shifts IN_W beats (MS slice first) into a word and
// flags the beat that completes it; the completed word is presented combinationally.
module iotdf_word_asm
  import iotdf_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int WORD_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              beat_en,
  input  logic [IN_W-1:0]   iot_in,
  output logic              first_beat,
  output logic              word_done,
  output logic [WORD_W-1:0] word
);

  localparam int N_BEATS = beats_of(WORD_W, IN_W);
  localparam int BC_W    = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(N_BEATS - 1);

  logic [BC_W-1:0] bcnt_reg;

  assign first_beat = (bcnt_reg == '0);
  assign word_done  = beat_en && (bcnt_reg == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_reg <= '0;
    end else if (beat_en) begin
      bcnt_reg <= word_done ? '0 : bcnt_reg + 1'b1;
    end
  end

  generate
    if (N_BEATS > 1) begin : g_multi
      logic [WORD_W-IN_W-1:0] shift_reg;

      assign word = {shift_reg, iot_in};

      always_ff @(posedge clk) begin
        if (rst) begin
          shift_reg <= '0;
        end else if (beat_en) begin
          shift_reg <= word[WORD_W-IN_W-1:0];
        end
      end
    end else begin : g_single
      assign word = iot_in;
    end
  endgenerate

endmodule

// File: rtl/iotdf_gen.sv
// IoT data-filter generator: assembles words from beats and, per round of
// N_WORDS words, reports MAX/MIN/AVG, threshold filters or a cross-round peak.
module iotdf_gen
  import iotdf_pkg::*;
#(
  parameter int IN_W    = 8,
  parameter int WORD_W  = 128,
  parameter int N_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_en,
  input  logic [IN_W-1:0]   iot_in,
  input  logic [2:0]        fn_sel,
  input  logic [WORD_W-1:0] thr_lo,
  input  logic [WORD_W-1:0] thr_hi,
  output logic              busy,
  output logic              valid,
  output logic [WORD_W-1:0] iot_out
);

  localparam int RW    = rnd_w_of(N_WORDS);
  localparam int ACC_W = WORD_W + RW;
  localparam logic [RW-1:0] LAST_WORD = RW'(N_WORDS - 1);

  state_e            state_reg, state_next;
  fn_e               mode_reg, cur_mode;
  logic [RW-1:0]     wcnt_reg;
  logic [WORD_W-1:0] ext_reg, ext_next;
  logic [ACC_W-1:0]  sum_reg, sum_next;
  logic [WORD_W-1:0] peak_reg, peak_cur, peak_next;
  logic              imp_reg, imp_cur, imp_next;
  logic              valid_reg, valid_next;
  logic [WORD_W-1:0] out_reg, out_next;

  logic              accept, first_beat, word_done;
  logic [WORD_W-1:0] word;
  logic              round_start, first_word, round_last;

  assign accept      = in_en && (state_reg == RUN);
  assign round_start = accept && first_beat && (wcnt_reg == '0);
  assign first_word  = word_done && (wcnt_reg == '0);
  assign round_last  = word_done && (wcnt_reg == LAST_WORD);
  // The opening beat already sees the new mode so single-beat words work.
  assign cur_mode    = round_start ? fn_e'(fn_sel) : mode_reg;

  iotdf_word_asm #(
    .IN_W  (IN_W),
    .WORD_W(WORD_W)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .beat_en   (accept),
    .iot_in    (iot_in),
    .first_beat(first_beat),
    .word_done (word_done),
    .word      (word)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (round_last) state_next = FIN;
      FIN:     state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    ext_next = ext_reg;
    if (first_word ||
        (cur_mode == FN_MAX && word > ext_reg) ||
        (cur_mode == FN_MIN && word < ext_reg)) begin
      ext_next = word;
    end
    sum_next = (first_word ? '0 : sum_reg) + ACC_W'(word);
  end

  // Peak restarts from its mode's neutral value when the mode changes between rounds.
  always_comb begin
    peak_cur = peak_reg;
    imp_cur  = imp_reg;
    if (round_start) begin
      imp_cur = 1'b0;
      if (fn_e'(fn_sel) != mode_reg) begin
        peak_cur = (fn_e'(fn_sel) == FN_PEAKMIN) ? '1 : '0;
      end
    end
    peak_next = peak_cur;
    imp_next  = imp_cur;
    if (word_done &&
        ((cur_mode == FN_PEAKMAX && word > peak_cur) ||
         (cur_mode == FN_PEAKMIN && word < peak_cur))) begin
      peak_next = word;
      imp_next  = 1'b1;
    end
  end

  always_comb begin
    valid_next = 1'b0;
    out_next   = out_reg;
    if (word_done) begin
      case (cur_mode)
        FN_EXTRACT: if (word > thr_lo && word < thr_hi) begin
          valid_next = 1'b1;
          out_next   = word;
        end
        FN_EXCLUDE: if (word < thr_lo || word > thr_hi) begin
          valid_next = 1'b1;
          out_next   = word;
        end
        default: ;
      endcase
    end
    if (round_last) begin
      case (cur_mode)
        FN_MAX, FN_MIN: begin
          valid_next = 1'b1;
          out_next   = ext_next;
        end
        FN_AVG: begin
          valid_next = 1'b1;
          out_next   = sum_next[ACC_W-1:RW];
        end
        FN_PEAKMAX, FN_PEAKMIN: if (imp_next) begin
          valid_next = 1'b1;
          out_next   = peak_next;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
      mode_reg  <= FN_IDLE;
      wcnt_reg  <= '0;
      ext_reg   <= '0;
      sum_reg   <= '0;
      peak_reg  <= '0;
      imp_reg   <= 1'b0;
      valid_reg <= 1'b0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (round_start) mode_reg <= fn_e'(fn_sel);
      if (word_done) begin
        wcnt_reg <= wcnt_reg + 1'b1;
        ext_reg  <= ext_next;
        sum_reg  <= sum_next;
      end
      peak_reg  <= peak_next;
      imp_reg   <= imp_next;
      valid_reg <= valid_next;
      out_reg   <= out_next;
    end
  end

  assign busy    = (state_reg == FIN);
  assign valid   = valid_reg;
  assign iot_out = out_reg;

endmodule

// File: tb/tb_iotdf_gen.sv
// Directed bench for iotdf_gen: a small 8/16/4 instance covers every mode,
// a default 8/128/8 instance repeats the gap / FIN-drop / reset scenario.
module tb_iotdf_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small instance
  logic        rst_a = 1'b1, in_en_a = 1'b0;
  logic [7:0]  iot_in_a = '0;
  logic [2:0]  fn_sel_a = '0;
  logic [15:0] thr_lo_a = '0, thr_hi_a = '0;
  logic        busy_a, valid_a;
  logic [15:0] iot_out_a;

  // default instance
  logic         rst_b = 1'b1, in_en_b = 1'b0;
  logic [7:0]   iot_in_b = '0;
  logic [2:0]   fn_sel_b = '0;
  logic [127:0] thr_lo_b = '0, thr_hi_b = '0;
  logic         busy_b, valid_b;
  logic [127:0] iot_out_b;

  iotdf_gen #(.IN_W(8), .WORD_W(16), .N_WORDS(4)) dut_a (
    .clk(clk), .rst(rst_a), .in_en(in_en_a), .iot_in(iot_in_a), .fn_sel(fn_sel_a),
    .thr_lo(thr_lo_a), .thr_hi(thr_hi_a), .busy(busy_a), .valid(valid_a), .iot_out(iot_out_a));

  iotdf_gen dut_b (
    .clk(clk), .rst(rst_b), .in_en(in_en_b), .iot_in(iot_in_b), .fn_sel(fn_sel_b),
    .thr_lo(thr_lo_b), .thr_hi(thr_hi_b), .busy(busy_b), .valid(valid_b), .iot_out(iot_out_b));

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  int done_a [4];

  logic [15:0]  vq_a [$];
  logic         bq_a [$];
  int           vc_a [$];
  logic [127:0] vq_b [$];
  logic         bq_b [$];
  logic [127:0] wb [8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_a) begin vq_a.push_back(iot_out_a); bq_a.push_back(busy_a); vc_a.push_back(cyc); end
    if (valid_b) begin vq_b.push_back(iot_out_b); bq_b.push_back(busy_b); end
  end

  task automatic clear_q();
    vq_a.delete(); bq_a.delete(); vc_a.delete(); vq_b.delete(); bq_b.delete();
  endtask

  task automatic send_a(input logic [15:0] w, input int gap);
    in_en_a = 1'b1; iot_in_a = w[15:8];
    @(negedge clk);
    if (gap > 0) begin in_en_a = 1'b0; repeat (gap) @(negedge clk); end
    in_en_a = 1'b1; iot_in_a = w[7:0];
    @(negedge clk);
    in_en_a = 1'b0;
  endtask

  // Sends a 4-word round; mode m2 is applied after the first word to prove latching.
  task automatic round_a(input logic [2:0] m, input logic [2:0] m2,
                         input logic [15:0] w0, w1, w2, w3, input int gap);
    fn_sel_a = m;
    send_a(w0, gap); done_a[0] = cyc; fn_sel_a = m2;
    send_a(w1, gap); done_a[1] = cyc;
    send_a(w2, gap); done_a[2] = cyc;
    send_a(w3, gap); done_a[3] = cyc;
    @(negedge clk);
    $display("round_a mode=%0d words %h %h %h %h -> %0d valid", m, w0, w1, w2, w3, vq_a.size());
  endtask

  task automatic send_b(input logic [127:0] w, input int gap);
    for (int i = 15; i >= 0; i--) begin
      in_en_b = 1'b1; iot_in_b = w[i*8 +: 8];
      @(negedge clk);
      if (gap > 0 && i != 0) begin in_en_b = 1'b0; repeat (gap) @(negedge clk); end
    end
    in_en_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (valid_a !== 1'b0)   begin n_fail++; $display("FAIL reset_valid_a got %b want 0", valid_a); end
    n_cmp++; if (busy_a !== 1'b0)    begin n_fail++; $display("FAIL reset_busy_a got %b want 0", busy_a); end
    n_cmp++; if (iot_out_a !== 16'h0) begin n_fail++; $display("FAIL reset_out_a got %h want 0", iot_out_a); end
    n_cmp++; if (valid_b !== 1'b0 || busy_b !== 1'b0 || iot_out_b !== 128'h0)
      begin n_fail++; $display("FAIL reset_b got v=%b b=%b out=%h want all 0", valid_b, busy_b, iot_out_b); end
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    $display("reset released");
  endtask

  task automatic test_max_min();
    clear_q();
    round_a(3'd1, 3'd1, 16'h0010, 16'h0300, 16'h0300, 16'h0002, 0);
    n_cmp++; if (vq_a.size() != 1) begin n_fail++; $display("FAIL max_count got %0d want 1", vq_a.size()); end
    else begin
      n_cmp++; if (vq_a[0] !== 16'h0300) begin n_fail++; $display("FAIL max_value got %h want 0300", vq_a[0]); end
      n_cmp++; if (bq_a[0] !== 1'b1) begin n_fail++; $display("FAIL max_busy got %b want 1", bq_a[0]); end
      n_cmp++; if (vc_a[0] != done_a[3]) begin n_fail++; $display("FAIL max_timing got cyc %0d want %0d", vc_a[0], done_a[3]); end
    end
    clear_q();
    round_a(3'd2, 3'd2, 16'h0500, 16'h0003, 16'h0700, 16'h0004, 0);
    n_cmp++; if (vq_a.size() != 1 || vq_a[0] !== 16'h0003)
      begin n_fail++; $display("FAIL min_value got n=%0d v=%h want 1 x 0003", vq_a.size(), (vq_a.size() > 0) ? vq_a[0] : 16'hx); end
  endtask

  task automatic test_avg();
    clear_q();
    round_a(3'd3, 3'd3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0);
    n_cmp++; if (vq_a.size() != 1 || vq_a[0] !== 16'hFFFF)
      begin n_fail++; $display("FAIL avg_full got n=%0d v=%h want 1 x FFFF", vq_a.size(), (vq_a.size() > 0) ? vq_a[0] : 16'hx); end
    clear_q();
    round_a(3'd3, 3'd3, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 0);
    n_cmp++; if (vq_a.size() != 1 || vq_a[0] !== 16'h0000)
      begin n_fail++; $display("FAIL avg_trunc got n=%0d v=%h want 1 x 0000", vq_a.size(), (vq_a.size() > 0) ? vq_a[0] : 16'hx); end
    // fn_sel switched to MAX after the first word must be ignored: (4+8+12+0)/4 = 6
    clear_q();
    round_a(3'd3, 3'd1, 16'h0004, 16'h0008, 16'h000C, 16'h0000, 0);
    n_cmp++; if (vq_a.size() != 1 || vq_a[0] !== 16'h0006)
      begin n_fail++; $display("FAIL avg_latch got n=%0d v=%h want 1 x 0006", vq_a.size(), (vq_a.size() > 0) ? vq_a[0] : 16'hx); end
  endtask

  task automatic test_filters();
    thr_lo_a = 16'h1000; thr_hi_a = 16'h2000;
    clear_q();
    round_a(3'd4, 3'd4, 16'h1000, 16'h1001, 16'h1FFF, 16'h2000, 0);
    n_cmp++; if (vq_a.size() != 2) begin n_fail++; $display("FAIL extract_count got %0d want 2", vq_a.size()); end
    else begin
      n_cmp++; if (vq_a[0] !== 16'h1001 || vq_a[1] !== 16'h1FFF)
        begin n_fail++; $display("FAIL extract_values got %h %h want 1001 1FFF", vq_a[0], vq_a[1]); end
      n_cmp++; if (vc_a[0] != done_a[1] || vc_a[1] != done_a[2])
        begin n_fail++; $display("FAIL extract_timing got %0d %0d want %0d %0d", vc_a[0], vc_a[1], done_a[1], done_a[2]); end
    end
    clear_q();
    round_a(3'd5, 3'd5, 16'h0FFF, 16'h1000, 16'h2001, 16'h2000, 0);
    n_cmp++; if (vq_a.size() != 2 || vq_a[0] !== 16'h0FFF || vq_a[1] !== 16'h2001)
      begin n_fail++; $display("FAIL exclude got n=%0d want 0FFF 2001", vq_a.size()); end
    thr_lo_a = 16'h2000; thr_hi_a = 16'h2000;
    clear_q();
    round_a(3'd4, 3'd4, 16'h1FFF, 16'h2000, 16'h2001, 16'h0000, 0);
    n_cmp++; if (vq_a.size() != 0) begin n_fail++; $display("FAIL extract_bad_thr got %0d valid want 0", vq_a.size()); end
    clear_q();
    round_a(3'd0, 3'd0, 16'h1234, 16'hFFFF, 16'h0000, 16'h8000, 0);
    n_cmp++; if (vq_a.size() != 0) begin n_fail++; $display("FAIL idle got %0d valid want 0", vq_a.size()); end
  endtask

  task automatic test_peak();
    clear_q();
    round_a(3'd6, 3'd6, 16'h0100, 16'h0500, 16'h0200, 16'h0000, 0);
    round_a(3'd6, 3'd6, 16'h0400, 16'h0001, 16'h0002, 16'h0003, 0);
    round_a(3'd6, 3'd6, 16'h0600, 16'h0010, 16'h0020, 16'h0030, 0);
    n_cmp++; if (vq_a.size() != 2) begin n_fail++; $display("FAIL peakmax_count got %0d want 2", vq_a.size()); end
    else begin
      n_cmp++; if (vq_a[0] !== 16'h0500 || vq_a[1] !== 16'h0600)
        begin n_fail++; $display("FAIL peakmax_values got %h %h want 0500 0600", vq_a[0], vq_a[1]); end
    end
    clear_q();
    round_a(3'd7, 3'd7, 16'h8000, 16'h9000, 16'hA000, 16'hB000, 0);
    n_cmp++; if (vq_a.size() != 1 || vq_a[0] !== 16'h8000)
      begin n_fail++; $display("FAIL peakmin_reinit got n=%0d v=%h want 1 x 8000", vq_a.size(), (vq_a.size() > 0) ? vq_a[0] : 16'hx); end
  endtask

  task automatic test_gaps_fin_reset_a();
    clear_q();
    fn_sel_a = 3'd1;
    send_a(16'h0001, 2); send_a(16'h0002, 1); send_a(16'h0003, 3); send_a(16'h0004, 1);
    n_cmp++; if (busy_a !== 1'b1 || valid_a !== 1'b1 || iot_out_a !== 16'h0004)
      begin n_fail++; $display("FAIL gap_fin_a got b=%b v=%b out=%h want 1 1 0004", busy_a, valid_a, iot_out_a); end
    in_en_a = 1'b1; iot_in_a = 8'hFF;       // offered during FIN, must be dropped
    @(negedge clk);
    in_en_a = 1'b0;
    clear_q();
    round_a(3'd2, 3'd2, 16'h0300, 16'h0100, 16'h0200, 16'h0400, 0);
    n_cmp++; if (vq_a.size() != 1 || vq_a[0] !== 16'h0100)
      begin n_fail++; $display("FAIL fin_drop_a got n=%0d v=%h want 1 x 0100", vq_a.size(), (vq_a.size() > 0) ? vq_a[0] : 16'hx); end
    fn_sel_a = 3'd1;
    send_a(16'h5678, 0);
    in_en_a = 1'b1; iot_in_a = 8'h9A;
    @(negedge clk);
    rst_a = 1'b1; iot_in_a = 8'hBC;         // in_en held high through reset
    repeat (2) @(negedge clk);
    rst_a = 1'b0; in_en_a = 1'b0;
    n_cmp++; if (valid_a !== 1'b0 || busy_a !== 1'b0 || iot_out_a !== 16'h0)
      begin n_fail++; $display("FAIL midrst_a got v=%b b=%b out=%h want 0 0 0000", valid_a, busy_a, iot_out_a); end
    clear_q();
    round_a(3'd1, 3'd1, 16'h0011, 16'h0022, 16'h0044, 16'h0033, 0);
    n_cmp++; if (vq_a.size() != 1 || vq_a[0] !== 16'h0044)
      begin n_fail++; $display("FAIL after_rst_a got n=%0d v=%h want 1 x 0044", vq_a.size(), (vq_a.size() > 0) ? vq_a[0] : 16'hx); end
  endtask

  task automatic test_defaults_b();
    logic [127:0] big;
    big = 128'h1 << 127;
    wb[0] = 128'd7; wb[1] = 128'hF0 << 100; wb[2] = 128'd9; wb[3] = 128'hFFFF;
    wb[4] = big;    wb[5] = 128'd3;         wb[6] = 128'd0; wb[7] = 128'd1;
    clear_q();
    fn_sel_b = 3'd1;
    for (int k = 0; k < 8; k++) send_b(wb[k], (k % 2 == 0) ? 1 : 0);
    n_cmp++; if (busy_b !== 1'b1 || valid_b !== 1'b1 || iot_out_b !== big)
      begin n_fail++; $display("FAIL max_b got b=%b v=%b out=%h want 1 1 %h", busy_b, valid_b, iot_out_b, big); end
    in_en_b = 1'b1; iot_in_b = 8'hEE;
    @(negedge clk);
    in_en_b = 1'b0;
    $display("round_b MAX -> %0d valid", vq_b.size());
    clear_q();
    fn_sel_b = 3'd2;
    for (int k = 0; k < 8; k++) send_b((k == 5) ? 128'd42 : 128'(100 + k), 0);
    @(negedge clk);
    $display("round_b MIN -> %0d valid", vq_b.size());
    n_cmp++; if (vq_b.size() != 1 || vq_b[0] !== 128'd42)
      begin n_fail++; $display("FAIL fin_drop_b got n=%0d v=%h want 1 x 42", vq_b.size(), (vq_b.size() > 0) ? vq_b[0] : 128'hx); end
    fn_sel_b = 3'd3;
    for (int k = 0; k < 3; k++) begin in_en_b = 1'b1; iot_in_b = 8'h55; @(negedge clk); end
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b0; in_en_b = 1'b0;
    n_cmp++; if (valid_b !== 1'b0 || busy_b !== 1'b0 || iot_out_b !== 128'h0)
      begin n_fail++; $display("FAIL midrst_b got v=%b b=%b out=%h want 0 0 0", valid_b, busy_b, iot_out_b); end
    clear_q();
    for (int k = 0; k < 8; k++) send_b(128'(8 * (k + 1)), 0);
    @(negedge clk);
    $display("round_b AVG -> %0d valid", vq_b.size());
    n_cmp++; if (vq_b.size() != 1 || vq_b[0] !== 128'd36)
      begin n_fail++; $display("FAIL avg_b got n=%0d v=%h want 1 x 36", vq_b.size(), (vq_b.size() > 0) ? vq_b[0] : 128'hx); end
  endtask

  initial begin
    test_reset();
    test_max_min();
    test_avg();
    test_filters();
    test_peak();
    test_gaps_fin_reset_a();
    test_defaults_b();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
